redirect_ctrl: RTL and testbench
================================

Name: redirect_ctrl

Overview:
- Request side of the frontend PC-redirect interface; the PC generator consumes what this block produces.
- Collects single-cycle redirect events from the backend (branch unit, commit stage, CSR/exception logic, debug), latches them per cause and resolves priority.
- Presents one resolved target PC at a time to the PC generator with a valid/ready handshake, then holds frontend flush for a fixed number of cycles.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core config; provides VLEN, DmBaseAddress, HaltAddress.
- FlushCycles, 2, cycles flush_if_o stays high after each accepted redirect; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- replay_i  in  1  fetch replay event pulse
- replay_addr_i  in  VLEN  replay PC
- mispredict_i  in  1  branch mispredict pulse
- mispredict_addr_i  in  VLEN  resolved branch target
- eret_i  in  1  xRET commit pulse
- eret_pc_i  in  VLEN  return PC
- ex_valid_i  in  1  exception/interrupt pulse
- trap_vector_base_i  in  VLEN  trap vector
- set_pc_commit_i  in  1  CSR side-effect flush pulse
- pc_commit_i  in  VLEN  PC of committing instruction
- halt_i  in  1  core halted (sampled with set_pc_commit_i)
- set_debug_pc_i  in  1  debug entry pulse
- redirect_ready_i  in  1  PC generator accepts redirect
- redirect_valid_o  out  1  redirect request
- redirect_pc_o  out  VLEN  target PC
- redirect_cause_o  out  3  0 none, 1 replay, 2 mispredict, 3 eret, 4 exception, 5 commit, 6 debug
- flush_if_o  out  1  kill fetch/instruction-queue contents
- busy_o  out  1  any pending cause or state not IDLE

Behaviour:
- Reset values: all outputs 0, all pending slots cleared, FSM in IDLE.
- Pending slots: one slot per cause, each a valid bit plus a VLEN address.
  - An event pulse with its slot empty sets the slot on the next edge.
  - A pulse arriving while its slot is full is dropped; the first-captured address is kept.
- Captured addresses are stored already resolved:
  - commit: pc_commit_i + 4, or + 0 if halt_i is high in the same cycle; sum wraps modulo 2^VLEN.
  - debug: DmBaseAddress + HaltAddress, truncated to VLEN.
  - all other causes: the input address as given.
- Priority, highest first: debug > exception > eret > commit > mispredict > replay.
- FSM IDLE:
  - If any slot is valid, select the highest-priority slot into the output register and go to REQ.
  - Earliest redirect_valid_o is 1 cycle after the event pulse.
- FSM REQ:
  - redirect_valid_o = 1.
  - pc and cause are frozen until the handshake (valid && ready), even if a higher-priority event arrives meanwhile.
  - On the handshake: clear the served slot and go to FLUSH with counter = FlushCycles-1.
  - If the served cause is debug, exception, eret or commit, also clear the mispredict and replay slots in the same edge (they belong to younger instructions).
- FSM FLUSH:
  - flush_if_o = 1, redirect_valid_o = 0.
  - Counter decrements each cycle; when it reaches 0, go to IDLE.
  - Events are still captured during FLUSH.
- Simultaneous events: every pulse in the same cycle is captured independently; the served order then follows priority.
- Pulse on the slot being served in the same cycle as its handshake: the clear and the capture coincide and the capture wins, so the new address becomes pending.
- Younger-slot clear vs. new capture in the same edge: a mispredict or replay pulse arriving on the clearing edge is discarded.
- Asynchronous reset mid-REQ or mid-FLUSH: returns to IDLE immediately; all slots are lost.

Optional Feature:
- Macro REDIRECT_CTRL_PERF_CNT_EN.
- When defined:
  - Adds output redirect_cnt_o (32 bits) counting accepted handshakes.
  - Adds output flush_cycle_cnt_o (32 bits) counting cycles with flush_if_o high.
  - Both reset to 0 and wrap on overflow.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Single mispredict_i at cycle 10 with addr 0x8000_1000, ready tied 1 -> cycle 11: valid=1, pc=0x8000_1000, cause=2; cycles 12-13: flush_if_o=1; cycle 14: busy_o=0.
- Backpressure: ready=0 for 5 cycles while set_debug_pc_i fires during an eret request (eret_pc 0x100) -> pc/cause stay 0x100/3 until ready, then debug served with pc = DmBaseAddress + HaltAddress, cause=6.
- mispredict_i, replay_i and ex_valid_i in the same cycle (trap base 0x8000_0000) -> only the exception is issued (cause=4); mispredict and replay slots are cleared and busy_o=0 after its flush.
- set_pc_commit_i with pc_commit 0x2000 and halt_i=0 -> pc 0x2004; repeat with halt_i=1 -> pc 0x2000; pc_commit = all-ones, halt_i=0 -> pc 0x3.
- Second mispredict_i (addr B) while slot holds A -> A issued, B never issued; pulse coinciding with A's handshake -> that address issued next.
- Reset asserted in FLUSH -> flush_if_o and busy_o drop asynchronously; with REDIRECT_CTRL_PERF_CNT_EN, redirect_cnt_o returns to 0.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: minimal core configuration consumed by the frontend redirect logic
package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
        logic [63:0] DmBaseAddress;
        logic [63:0] HaltAddress;
    } cva6_cfg_t;
    localparam cva6_cfg_t cva6_cfg_empty = '{
        VLEN: 32,
        DmBaseAddress: 64'h0,
        HaltAddress: 64'h800
    };
endpackage

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: latches backend redirect causes, resolves priority, issues one PC redirect at a time then flushes fetch (optional REDIRECT_CTRL_PERF_CNT_EN adds perf counters)
module redirect_ctrl #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned FlushCycles = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      replay_i,
    input  logic [CVA6Cfg.VLEN-1:0]   replay_addr_i,
    input  logic                      mispredict_i,
    input  logic [CVA6Cfg.VLEN-1:0]   mispredict_addr_i,
    input  logic                      eret_i,
    input  logic [CVA6Cfg.VLEN-1:0]   eret_pc_i,
    input  logic                      ex_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]   trap_vector_base_i,
    input  logic                      set_pc_commit_i,
    input  logic [CVA6Cfg.VLEN-1:0]   pc_commit_i,
    input  logic                      halt_i,
    input  logic                      set_debug_pc_i,
    input  logic                      redirect_ready_i,
    output logic                      redirect_valid_o,
    output logic [CVA6Cfg.VLEN-1:0]   redirect_pc_o,
    output logic [2:0]                redirect_cause_o,
    output logic                      flush_if_o,
`ifdef REDIRECT_CTRL_PERF_CNT_EN
    output logic [31:0]               redirect_cnt_o,
    output logic [31:0]               flush_cycle_cnt_o,
`endif
    output logic                      busy_o
);
    localparam int unsigned VLEN = CVA6Cfg.VLEN;
    localparam logic [63:0] DBG_FULL = CVA6Cfg.DmBaseAddress + CVA6Cfg.HaltAddress;
    localparam logic [VLEN-1:0] DBG_PC = DBG_FULL[VLEN-1:0];

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_e;

    // Slots are kept in ascending priority: replay, mispredict, commit, eret, exception, debug
    state_e          state_q, state_d;
    logic [5:0]      ev, pend_q, pend_d, cap, served, young, eff;
    logic [VLEN-1:0] ev_addr [6];
    logic [VLEN-1:0] addr_q [6];
    logic [2:0]      sel_q, sel_d, pick;
    logic [VLEN-1:0] pc_q, pc_d, pick_pc;
    logic [3:0]      cnt_q, cnt_d;
    logic            hs;

    // Gather event pulses and their already-resolved target addresses
    always_comb begin
        ev = {set_debug_pc_i, ex_valid_i, eret_i, set_pc_commit_i, mispredict_i, replay_i};
        ev_addr[0] = replay_addr_i;
        ev_addr[1] = mispredict_addr_i;
        ev_addr[2] = pc_commit_i + (halt_i ? VLEN'(0) : VLEN'(4));
        ev_addr[3] = eret_pc_i;
        ev_addr[4] = trap_vector_base_i;
        ev_addr[5] = DBG_PC;
    end

    // Slot bookkeeping: served/younger clears, capture-wins on the served slot, younger pulses lost on their clearing edge
    always_comb begin
        hs = (state_q == REQ) && redirect_ready_i;
        served = hs ? 6'(6'd1 << sel_q) : 6'd0;
        young = (hs && sel_q >= 3'd2) ? 6'b000011 : 6'd0;
        cap = ev & ~young & (~pend_q | served);
        pend_d = (pend_q & ~(served | young)) | cap;
        eff = pend_q | ev;
        pick = '0;
        pick_pc = '0;
        for (int i = 0; i < 6; i++) begin
            if (eff[i]) begin
                pick = 3'(i);
                pick_pc = pend_q[i] ? addr_q[i] : ev_addr[i];
            end
        end
    end

    // Next-state and output decode for the IDLE/REQ/FLUSH sequencer
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        pc_d = pc_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (|eff) begin
                state_d = REQ;
                sel_d = pick;
                pc_d = pick_pc;
            end
            REQ: if (redirect_ready_i) begin
                state_d = FLUSH;
                cnt_d = 4'(FlushCycles - 1);
            end
            FLUSH: if (cnt_q == 4'd0) state_d = IDLE;
                   else cnt_d = cnt_q - 4'd1;
            default: state_d = IDLE;
        endcase
        redirect_valid_o = state_q == REQ;
        flush_if_o = state_q == FLUSH;
        redirect_pc_o = redirect_valid_o ? pc_q : '0;
        redirect_cause_o = !redirect_valid_o ? 3'd0 :
                           sel_q == 3'd2 ? 3'd5 :
                           sel_q == 3'd3 ? 3'd3 :
                           sel_q == 3'd4 ? 3'd4 :
                           sel_q == 3'd5 ? 3'd6 : 3'(sel_q + 3'd1);
        busy_o = (|pend_q) || (state_q != IDLE);
    end

    // Sequencer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Pending slots, selected request and flush counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            sel_q <= '0;
            pc_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < 6; i++) addr_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
            sel_q <= sel_d;
            pc_q <= pc_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < 6; i++) if (cap[i]) addr_q[i] <= ev_addr[i];
        end
    end

`ifdef REDIRECT_CTRL_PERF_CNT_EN
    // Free-running wrap-around counts of accepted redirects and flush cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_cnt_o <= '0;
            flush_cycle_cnt_o <= '0;
        end else begin
            redirect_cnt_o <= redirect_cnt_o + 32'(hs);
            flush_cycle_cnt_o <= flush_cycle_cnt_o + 32'(flush_if_o);
        end
    end
`endif
endmodule

// File: tb/tb_redirect_ctrl.sv
// tb_redirect_ctrl: directed checks of redirect_ctrl priority, backpressure, flush timing and reset
module tb_redirect_ctrl;
    localparam logic [31:0] DBG = 32'h0000_0800;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic replay_i = 0, mispredict_i = 0, eret_i = 0, ex_valid_i = 0;
    logic set_pc_commit_i = 0, halt_i = 0, set_debug_pc_i = 0, redirect_ready_i = 1;
    logic [31:0] replay_addr_i = 0, mispredict_addr_i = 0, eret_pc_i = 0;
    logic [31:0] trap_vector_base_i = 0, pc_commit_i = 0, redirect_pc_o;
    logic redirect_valid_o, flush_if_o, busy_o;
    logic [2:0] redirect_cause_o;
`ifdef REDIRECT_CTRL_PERF_CNT_EN
    logic [31:0] redirect_cnt_o, flush_cycle_cnt_o;
`endif
    int n = 0, errs = 0;

    redirect_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .replay_i(replay_i), .replay_addr_i(replay_addr_i),
        .mispredict_i(mispredict_i), .mispredict_addr_i(mispredict_addr_i),
        .eret_i(eret_i), .eret_pc_i(eret_pc_i),
        .ex_valid_i(ex_valid_i), .trap_vector_base_i(trap_vector_base_i),
        .set_pc_commit_i(set_pc_commit_i), .pc_commit_i(pc_commit_i), .halt_i(halt_i),
        .set_debug_pc_i(set_debug_pc_i), .redirect_ready_i(redirect_ready_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_cause_o(redirect_cause_o), .flush_if_o(flush_if_o),
`ifdef REDIRECT_CTRL_PERF_CNT_EN
        .redirect_cnt_o(redirect_cnt_o), .flush_cycle_cnt_o(flush_cycle_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        {replay_i, mispredict_i, eret_i, ex_valid_i, set_pc_commit_i, set_debug_pc_i} = '0;
    endtask

    task automatic serve(input string tag, input logic [31:0] pc, input logic [2:0] cause);
        tick();
        chk({tag, "_valid"}, 32'(redirect_valid_o), 1);
        chk({tag, "_pc"}, redirect_pc_o, pc);
        chk({tag, "_cause"}, 32'(redirect_cause_o), 32'(cause));
        tick(); tick(); tick();
        chk({tag, "_idle"}, 32'(busy_o), 0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_valid", 32'(redirect_valid_o), 0);
        chk("rst_pc", redirect_pc_o, 0);
        chk("rst_cause", 32'(redirect_cause_o), 0);
        chk("rst_flush", 32'(flush_if_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst_ni = 1;
        tick(); tick();
        // single mispredict with ready tied high
        mispredict_i = 1; mispredict_addr_i = 32'h8000_1000;
        tick();
        chk("mp_valid", 32'(redirect_valid_o), 1);
        chk("mp_pc", redirect_pc_o, 32'h8000_1000);
        chk("mp_cause", 32'(redirect_cause_o), 2);
        chk("mp_flush0", 32'(flush_if_o), 0);
        tick();
        chk("mp_flush1", 32'(flush_if_o), 1);
        chk("mp_novalid", 32'(redirect_valid_o), 0);
        tick();
        chk("mp_flush2", 32'(flush_if_o), 1);
        tick();
        chk("mp_flush_end", 32'(flush_if_o), 0);
        chk("mp_busy", 32'(busy_o), 0);
        // backpressure: debug arrives while eret is held
        redirect_ready_i = 0; eret_i = 1; eret_pc_i = 32'h100;
        tick();
        chk("bp_pc", redirect_pc_o, 32'h100);
        chk("bp_cause", 32'(redirect_cause_o), 3);
        set_debug_pc_i = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_pc", redirect_pc_o, 32'h100);
            chk("bp_hold_cause", 32'(redirect_cause_o), 3);
        end
        redirect_ready_i = 1;
        tick();
        chk("bp_flush", 32'(flush_if_o), 1);
        tick(); tick();
        chk("bp_gap_busy", 32'(busy_o), 1);
        serve("bp_dbg", DBG, 6);
        // simultaneous mispredict, replay, exception
        mispredict_i = 1; mispredict_addr_i = 32'h1111_0000;
        replay_i = 1; replay_addr_i = 32'h2222_0000;
        ex_valid_i = 1; trap_vector_base_i = 32'h8000_0000;
        serve("sim_ex", 32'h8000_0000, 4);
        tick();
        chk("sim_no_younger", 32'(redirect_valid_o), 0);
        // commit target resolution
        set_pc_commit_i = 1; pc_commit_i = 32'h2000; halt_i = 0;
        serve("cm_plus4", 32'h2004, 5);
        set_pc_commit_i = 1; halt_i = 1;
        serve("cm_halt", 32'h2000, 5);
        set_pc_commit_i = 1; pc_commit_i = 32'hFFFF_FFFF; halt_i = 0;
        serve("cm_wrap", 32'h3, 5);
        // second mispredict dropped while slot is full
        redirect_ready_i = 0; mispredict_i = 1; mispredict_addr_i = 32'hA000;
        tick();
        chk("dup_a", redirect_pc_o, 32'hA000);
        mispredict_i = 1; mispredict_addr_i = 32'hB000;
        tick();
        chk("dup_a_hold", redirect_pc_o, 32'hA000);
        redirect_ready_i = 1;
        tick(); tick(); tick();
        chk("dup_b_dropped", 32'(busy_o), 0);
        // pulse coinciding with handshake becomes pending
        redirect_ready_i = 0; mispredict_i = 1; mispredict_addr_i = 32'hA100;
        tick();
        chk("coin_a", redirect_pc_o, 32'hA100);
        redirect_ready_i = 1; mispredict_i = 1; mispredict_addr_i = 32'hC000;
        tick();
        chk("coin_busy", 32'(busy_o), 1);
        tick(); tick();
        serve("coin_c", 32'hC000, 2);
        // younger pulse on the clearing edge is discarded
        redirect_ready_i = 0; eret_i = 1; eret_pc_i = 32'h300;
        tick();
        chk("yc_eret", redirect_pc_o, 32'h300);
        redirect_ready_i = 1; mispredict_i = 1; mispredict_addr_i = 32'h400;
        tick(); tick(); tick();
        chk("yc_discard", 32'(busy_o), 0);
        // async reset during flush
        mispredict_i = 1; mispredict_addr_i = 32'h500;
        tick(); tick();
        chk("ar_flush_pre", 32'(flush_if_o), 1);
        #2 rst_ni = 0;
        #1;
        chk("ar_flush", 32'(flush_if_o), 0);
        chk("ar_busy", 32'(busy_o), 0);
        chk("ar_valid", 32'(redirect_valid_o), 0);
`ifdef REDIRECT_CTRL_PERF_CNT_EN
        chk("ar_redirect_cnt", redirect_cnt_o, 0);
        chk("ar_flush_cnt", flush_cycle_cnt_o, 0);
`endif
        tick();
        rst_ni = 1;
        tick();
        chk("post_rst_busy", 32'(busy_o), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
